// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared state encoding, NOP constants and hazard helper for
//               the pipeline controller.
// Revision    : 1.0
// ============================================================================
package pipeline_pkg;

    localparam int C_REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN            = 2'd0,
        ST_MEM_WAIT       = 2'd1,
        ST_MEM_WAIT_REDIR = 2'd2
    } pc_state_e;

    localparam logic [31:0]        C_ZERO_INSTR = 32'h0000_0000;
    localparam logic [31:0]        C_NOP_INSTR  = 32'h0000_0013;
    localparam logic [C_REG_W-1:0] C_ZERO_REG   = '0;

    // x0 is hardwired to zero, so a load targeting it can never create a hazard.
    function automatic logic load_use_hazard(
        input logic               mem_read,
        input logic [C_REG_W-1:0] rd,
        input logic [C_REG_W-1:0] rs1,
        input logic [C_REG_W-1:0] rs2
    );
        return mem_read && (rd != C_ZERO_REG) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that holds at all-ones instead of wrapping.
// Revision    : 1.0
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] C_MAX = '1;

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != C_MAX)) begin
            r_count <= r_count + C_ONE;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_controller
// Description : Hazard, instruction-memory stall and branch-redirect control
//               for a five-stage pipeline, with performance counters.
// Revision    : 1.0
// ============================================================================
module pipeline_controller
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int XLEN  = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [C_REG_W-1:0] ifid_rs1,
    input  logic [C_REG_W-1:0] ifid_rs2,
    input  logic               idex_mem_read,
    input  logic [C_REG_W-1:0] idex_rd,
    input  logic               branch_taken,
    input  logic [XLEN-1:0]    branch_target,
    input  logic               imem_ready,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic               idex_bubble,
    output logic               pc_sel,
    output logic [XLEN-1:0]    redirect_pc,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   flush_count
);

    pc_state_e        r_state;
    pc_state_e        w_next_state;
    logic [XLEN-1:0]  r_pending_target;
    logic             w_latch_target;
    logic             w_stall_inc;
    logic             w_flush_inc;
    logic             w_hazard;

    always_comb begin
        w_hazard       = load_use_hazard(idex_mem_read, idex_rd, ifid_rs1, ifid_rs2);
        pc_write       = 1'b0;
        ifid_write     = 1'b0;
        ifid_flush     = 1'b0;
        idex_bubble    = 1'b0;
        pc_sel         = 1'b0;
        redirect_pc    = r_pending_target;
        w_next_state   = r_state;
        w_latch_target = 1'b0;
        w_stall_inc    = 1'b0;
        w_flush_inc    = 1'b0;

        if (reset) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (r_state)
                ST_MEM_WAIT_REDIR: begin
                    // The flush was already counted when the redirect was first seen.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (imem_ready) begin
                        pc_sel       = 1'b1;
                        pc_write     = 1'b1;
                        w_next_state = ST_RUN;
                        if (branch_taken) begin
                            redirect_pc = branch_target;
                        end
                    end else if (branch_taken) begin
                        w_latch_target = 1'b1;
                    end
                end
                default: begin
                    // RUN and MEM_WAIT react identically to the current inputs.
                    if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        w_flush_inc = 1'b1;
                        if (imem_ready) begin
                            pc_sel       = 1'b1;
                            pc_write     = 1'b1;
                            redirect_pc  = branch_target;
                            w_next_state = ST_RUN;
                        end else begin
                            w_latch_target = 1'b1;
                            w_next_state   = ST_MEM_WAIT_REDIR;
                        end
                    end else if (!imem_ready) begin
                        idex_bubble  = 1'b1;
                        w_stall_inc  = 1'b1;
                        w_next_state = ST_MEM_WAIT;
                    end else if (w_hazard) begin
                        idex_bubble  = 1'b1;
                        w_stall_inc  = 1'b1;
                        w_next_state = ST_RUN;
                    end else begin
                        pc_write     = 1'b1;
                        ifid_write   = 1'b1;
                        w_next_state = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_RUN;
            r_pending_target <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_latch_target) begin
                r_pending_target <= branch_target;
            end
        end
    end

    sat_counter #(
        .WIDTH   (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (w_stall_inc),
        .o_count (stall_cycles)
    );

    sat_counter #(
        .WIDTH   (CNT_W)
    ) u_flush_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_inc   (w_flush_inc),
        .o_count (flush_count)
    );

endmodule : pipeline_controller
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_controller
// Description : Directed and random stimulus against a behavioural model of
//               the pipeline controller.
// Revision    : 1.0
// ============================================================================
module tb_pipeline_controller;

    localparam int CNT_W = 4;
    localparam int XLEN  = 64;
    localparam int C_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       ifid_rs1, ifid_rs2, idex_rd;
    logic             idex_mem_read, branch_taken, imem_ready;
    logic [XLEN-1:0]  branch_target;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble, pc_sel;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int checks = 0;
    int errors = 0;

    // Model: only an owed redirect changes how inputs map to outputs.
    bit              m_owed  = 1'b0;
    logic [XLEN-1:0] m_pend  = '0;
    int              m_stall = 0;
    int              m_flush = 0;

    always #5 clk = ~clk;

    pipeline_controller #(.CNT_W(CNT_W), .XLEN(XLEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_ready    (imem_ready),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .pc_sel        (pc_sel),
        .redirect_pc   (redirect_pc),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic br, input logic [XLEN-1:0] tgt,
                        input logic rdy, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
        logic e_pcw, e_ifw, e_fl, e_bub, e_sel, chk_ifw, lu;
        logic [XLEN-1:0] e_red;
        reset = rst; branch_taken = br; branch_target = tgt; imem_ready = rdy;
        idex_mem_read = mr; idex_rd = rd; ifid_rs1 = rs1; ifid_rs2 = rs2;
        #1;
        chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        chk("flush_count", 64'(flush_count), 64'(m_flush));
        lu = mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
        e_pcw = 0; e_ifw = 0; e_fl = 0; e_bub = 0; e_sel = 0; e_red = m_pend; chk_ifw = 1;
        if (rst) begin
            e_fl = 1; e_bub = 1;
        end else if (m_owed) begin
            e_fl = 1; e_bub = 1; chk_ifw = 0;
            if (rdy) begin e_sel = 1; e_pcw = 1; end
        end else if (br) begin
            e_fl = 1; e_bub = 1; chk_ifw = 0;
            if (rdy) begin e_sel = 1; e_pcw = 1; e_red = tgt; end
        end else if (!rdy || lu) begin
            e_bub = 1;
        end else begin
            e_pcw = 1; e_ifw = 1;
        end
        chk("pc_write", 64'(pc_write), 64'(e_pcw));
        chk("ifid_flush", 64'(ifid_flush), 64'(e_fl));
        chk("idex_bubble", 64'(idex_bubble), 64'(e_bub));
        chk("pc_sel", 64'(pc_sel), 64'(e_sel));
        chk("redirect_pc", redirect_pc, e_red);
        if (chk_ifw) chk("ifid_write", 64'(ifid_write), 64'(e_ifw));
        // Advance the model to what the coming edge should produce.
        if (rst) begin
            m_owed = 0; m_pend = '0; m_stall = 0; m_flush = 0;
        end else if (m_owed) begin
            if (rdy) m_owed = 0;
            else if (br) m_pend = tgt;
        end else if (br) begin
            if (m_flush < C_MAX) m_flush++;
            if (!rdy) begin m_owed = 1; m_pend = tgt; end
        end else if (!rdy || lu) begin
            if (m_stall < C_MAX) m_stall++;
        end
        @(negedge clk);
    endtask

    initial begin
        logic br, rdy, mr;
        reset = 1; branch_taken = 0; branch_target = '0; imem_ready = 1;
        idex_mem_read = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0;
        @(negedge clk);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        step(1, 1, 64'h55, 0, 1, 3, 3, 0);
        // Load-use stall, then x0 destination never stalls.
        step(0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0);
        step(0, 0, 0, 1, 0, 5'd5, 5'd5, 5'd0);
        chk("stall_after_load_use", 64'(stall_cycles), 64'd1);
        step(0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd7);
        // Immediate branch redirect.
        step(0, 1, 64'h1000, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        chk("flush_after_branch", 64'(flush_count), 64'd1);
        // Branch resolved while fetch is stalled.
        step(1, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 64'h2000, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        chk("stall_mem_redir", 64'(stall_cycles), 64'd1);
        chk("flush_mem_redir", 64'(flush_count), 64'd1);
        // Newest branch wins while redirect is owed.
        step(0, 1, 64'h3000, 0, 0, 0, 0, 0);
        step(0, 1, 64'h4000, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        // Branch beats a simultaneous load-use hazard.
        step(0, 1, 64'h5000, 1, 1, 5'd9, 5'd9, 5'd9);
        // Reset discards an owed redirect.
        step(0, 1, 64'h6000, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        chk("no_redirect_after_reset", 64'(pc_sel), 64'd0);
        // Saturation of the stall counter.
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall_saturated", 64'(stall_cycles), 64'(C_MAX));
        for (int i = 0; i < 20; i++) step(0, 1, 64'(i), 1, 0, 0, 0, 0);
        chk("flush_saturated", 64'(flush_count), 64'(C_MAX));
        step(1, 0, 0, 1, 0, 0, 0, 0);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            br  = ($urandom_range(0, 99) < 15);
            rdy = ($urandom_range(0, 99) < 65);
            mr  = ($urandom_range(0, 99) < 50);
            if (m_owed && br && rdy) br = 0;
            step(($urandom_range(0, 99) < 2), br, {$urandom, $urandom}, rdy, mr,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipeline_controller
`default_nettype wire
